db15_joy_responder: RTL and testbench

DB15_JOY_RESPONDER -- requirements
Module: db15_joy_responder

---
 rtl/db15_joy_responder.sv | 114 +++++++++++
 tb/tb_db15_joy_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/db15_joy_responder.sv
// db15_joy_responder: DB15 joystick adapter that answers the host's load/clock serial poll with two 16-bit pads.
// Optional DB15_JOY_CHAIN_EN adds ser_in so shifted-out frames are refilled from a downstream adapter.
module db15_joy_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        joy_load,
    input  logic        joy_clk,
`ifdef DB15_JOY_CHAIN_EN
    input  logic        ser_in,
`endif
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic        frame_done,
    output logic        link_active
);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                 state, state_n;
    logic [1:0]             rst_q;
    logic [SYNC_STAGES-1:0] ld_sync, ck_sync;
    logic                   ld_q, ck_q;
    logic [31:0]            shift, shift_n;
    logic [5:0]             cnt, cnt_n;
    logic [IW-1:0]          idle_cnt;
    logic                   data_n, done_n, fill, en;
    logic                   ld_s, ck_s, ld_low, ld_fall, ld_rise, ck_rise, idle_sat;

`ifdef DB15_JOY_CHAIN_EN
    assign fill = ser_in;
`else
    assign fill = 1'b0;
`endif

    // reset is applied asynchronously but released only after two clk edges
    assign en       = rst_q[1];
    assign ld_s     = ld_sync[SYNC_STAGES-1];
    assign ck_s     = ck_sync[SYNC_STAGES-1];
    assign ld_low   = ~ld_s;
    assign ld_fall  = ld_q & ~ld_s;
    assign ld_rise  = ~ld_q & ld_s;
    assign ck_rise  = ~ck_q & ck_s;
    assign idle_sat = idle_cnt == IW'(IDLE_CYCLES);
    assign link_active = ~idle_sat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_q   <= '0;
            ld_sync <= '1;
            ck_sync <= '1;
            ld_q    <= 1'b1;
            ck_q    <= 1'b1;
        end else begin
            rst_q   <= {rst_q[0], 1'b1};
            ld_sync <= {ld_sync[SYNC_STAGES-2:0], joy_load};
            ck_sync <= {ck_sync[SYNC_STAGES-2:0], joy_clk};
            ld_q    <= ld_s;
            ck_q    <= ck_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= '0;
            cnt        <= '0;
            idle_cnt   <= IW'(IDLE_CYCLES);
            joy_data   <= 1'b1;
            frame_done <= 1'b0;
        end else if (en) begin
            state      <= state_n;
            shift      <= shift_n;
            cnt        <= cnt_n;
            idle_cnt   <= ld_fall ? '0 : idle_sat ? idle_cnt : idle_cnt + IW'(1);
            joy_data   <= data_n;
            frame_done <= done_n;
        end
    end

    // load wins over everything, then the idle timeout, then shifting
    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = cnt;
        data_n  = joy_data;
        done_n  = 1'b0;
        if (ld_low) begin
            state_n = LOAD;
            shift_n = {joystick2, joystick1};
            cnt_n   = '0;
            data_n  = ~joystick1[0];
        end else if (idle_sat) begin
            state_n = IDLE;
            data_n  = 1'b1;
        end else begin
            case (state)
                IDLE: data_n = 1'b1;
                LOAD: state_n = ld_rise ? SHIFT : LOAD;
                default: if (ck_rise) begin
                    shift_n = {fill, shift[31:1]};
                    data_n  = ~shift[1];
                    cnt_n   = (state == SHIFT) ? cnt + 6'd1 : cnt;
                    done_n  = (state == SHIFT) && (cnt == 6'd31);
                    state_n = done_n ? DONE : state;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_db15_joy_responder.sv
// tb_db15_joy_responder: table-driven frame checks plus load/reset/idle corner sequences for db15_joy_responder.
module tb_db15_joy_responder;
    localparam int SS = 2;
    localparam int IC = 1000;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        int          n;
        int          exp_done;
    } vec_t;

    logic        clk = 1'b0, reset_n = 1'b0, joy_load = 1'b1, joy_clk = 1'b0;
    logic [15:0] joystick1 = '0, joystick2 = '0;
    logic        joy_data, frame_done, link_active;
    int          total = 0, bad = 0, done_cnt = 0;
    logic        exp_q[$];
    vec_t        vecs[5];
`ifdef DB15_JOY_CHAIN_EN
    logic        ser_in = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

    db15_joy_responder #(.SYNC_STAGES(SS), .IDLE_CYCLES(IC)) dut (
        .clk(clk), .reset_n(reset_n), .joy_load(joy_load), .joy_clk(joy_clk),
`ifdef DB15_JOY_CHAIN_EN
        .ser_in(ser_in),
`endif
        .joystick1(joystick1), .joystick2(joystick2),
        .joy_data(joy_data), .frame_done(frame_done), .link_active(link_active)
    );

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_pulse(input logic [15:0] a, input logic [15:0] b);
        joystick1 = a;
        joystick2 = b;
        joy_load  = 1'b0;
        cyc(8);
        joy_load  = 1'b1;
        cyc(8);
    endtask

    function automatic logic wire_bit(input logic [31:0] f, input int k, input logic fl);
        return (k < 32) ? ~f[k] : ~fl;
    endfunction

    // scoreboard: the expected wire bit is queued as each host clock is driven
    task automatic run_clocks(input string nm, input logic [31:0] f, input int n, input logic fl);
        exp_q.push_back(wire_bit(f, 0, fl));
        check($sformatf("%s bit1", nm), joy_data, exp_q.pop_front());
        for (int i = 1; i <= n; i++) begin
            exp_q.push_back(wire_bit(f, i, fl));
            joy_clk = 1'b1;
            cyc(6);
            check($sformatf("%s bit%0d", nm, i + 1), joy_data, exp_q.pop_front());
            joy_clk = 1'b0;
            cyc(6);
        end
    endtask

    initial begin
        int d0;
        vecs[0] = '{16'h0015, 16'h0200, 32, 1};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32, 1};
        vecs[2] = '{16'hA5A5, 16'h5A5A, 33, 1};
        vecs[3] = '{16'h8001, 16'h8001, 40, 1};
        vecs[4] = '{16'h1234, 16'h0000, 20, 0};

        cyc(3);
        check("rst joy_data", joy_data, 1'b1);
        check("rst frame_done", frame_done, 1'b0);
        check("rst link_active", link_active, 1'b0);
        reset_n = 1'b1;
        cyc(4);
        check("post-rst idle joy_data", joy_data, 1'b1);

        foreach (vecs[v]) begin
            d0 = done_cnt;
            load_pulse(vecs[v].j1, vecs[v].j2);
            check($sformatf("v%0d link_active", v), link_active, 1'b1);
            run_clocks($sformatf("v%0d", v), {vecs[v].j2, vecs[v].j1}, vecs[v].n, 1'b0);
            check_int($sformatf("v%0d frame_done count", v), done_cnt - d0, vecs[v].exp_done);
        end

        // load asserted together with the 10th host clock edge
        d0 = done_cnt;
        load_pulse(16'h0F0F, 16'h3C3C);
        run_clocks("pre", {16'h3C3C, 16'h0F0F}, 9, 1'b0);
        joystick1 = 16'h00F1;
        joystick2 = 16'h8000;
        joy_load  = 1'b0;
        joy_clk   = 1'b1;
        cyc(8);
        joy_load  = 1'b1;
        cyc(8);
        joy_clk   = 1'b0;
        cyc(6);
        run_clocks("reload", {16'h8000, 16'h00F1}, 32, 1'b0);
        check_int("reload frame_done count", done_cnt - d0, 1);

        // idle timeout
        cyc(IC + 10);
        check("idle link_active", link_active, 1'b0);
        check("idle joy_data", joy_data, 1'b1);
        joy_clk = 1'b1;
        cyc(6);
        joy_clk = 1'b0;
        cyc(6);
        check("idle clk ignored", joy_data, 1'b1);
        load_pulse(16'h0002, 16'h0000);
        check("relink link_active", link_active, 1'b1);
        check("relink joy_data", joy_data, 1'b1);

        // reset in the middle of a frame
        d0 = done_cnt;
        load_pulse(16'hC3C3, 16'h0F0F);
        run_clocks("abort", {16'h0F0F, 16'hC3C3}, 15, 1'b0);
        joy_clk = 1'b1;
        cyc(2);
        reset_n = 1'b0;
        #1;
        check("abort joy_data", joy_data, 1'b1);
        check("abort frame_done", frame_done, 1'b0);
        cyc(3);
        joy_clk = 1'b0;
        reset_n = 1'b1;
        cyc(4);
        load_pulse(16'h6E21, 16'h9D4B);
        run_clocks("after rst", {16'h9D4B, 16'h6E21}, 32, 1'b0);
        check_int("abort frame_done count", done_cnt - d0, 1);

`ifdef DB15_JOY_CHAIN_EN
        ser_in = 1'b1;
        d0 = done_cnt;
        load_pulse(16'h0015, 16'h0200);
        run_clocks("chain", {16'h0200, 16'h0015}, 34, 1'b1);
        check_int("chain frame_done count", done_cnt - d0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
